// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone arbiter (m0 = instruction fetch, m1 = LSU)
// onto one shared slave bus, with a registered grant FSM, round-robin or fixed
// tie-break, and a no-ack watchdog that pulses the owner's err output.
// Ports:
//   clk_i, reset_i (async, active-low)
//   m{0,1}adr_i/dat_i/we_i/stb_i/cyc_i : master requests
//   m{0,1}ack_o/err_o/stall_o/dat_o    : per-master responses
//   wbsadr_o/dat_o/we_o/stb_o/cyc_o    : shared slave-side bus
//   wbsack_i, wbsdat_i                 : slave acknowledge and read data
//   gnt_o                              : {owner1, owner0}
module wb_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TMO_CYCLES  = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] m0adr_i,
    input  logic [63:0] m1adr_i,
    input  logic [15:0] m0dat_i,
    input  logic [15:0] m1dat_i,
    input  logic        m0we_i,
    input  logic        m1we_i,
    input  logic        m0stb_i,
    input  logic        m1stb_i,
    input  logic        m0cyc_i,
    input  logic        m1cyc_i,
    output logic        m0ack_o,
    output logic        m1ack_o,
    output logic        m0err_o,
    output logic        m1err_o,
    output logic        m0stall_o,
    output logic        m1stall_o,
    output logic [15:0] m0dat_o,
    output logic [15:0] m1dat_o,
    output logic [63:0] wbsadr_o,
    output logic [15:0] wbsdat_o,
    output logic        wbswe_o,
    output logic        wbsstb_o,
    output logic        wbscyc_o,
    input  logic        wbsack_i,
    input  logic [15:0] wbsdat_i,
    output logic [1:0]  gnt_o
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [15:0] TMO_M1 = 16'(TMO_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic [15:0] r_cnt;
    logic        w_own0;
    logic        w_own1;
    logic        w_busy;
    logic        w_expire;

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);

    // r_last holds the previous owner; a tie goes to the other master
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (m0cyc_i && m1cyc_i) ? (((ROUND_ROBIN != 0) && r_last) ? OWN0 : OWN1) :
                              m0cyc_i ? OWN0 : m1cyc_i ? OWN1 : IDLE;
            OWN0:    w_next = m0cyc_i ? OWN0 : m1cyc_i ? OWN1 : IDLE;
            OWN1:    w_next = m1cyc_i ? OWN1 : m0cyc_i ? OWN0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign wbsadr_o = w_own0 ? m0adr_i : w_own1 ? m1adr_i : '0;
    assign wbsdat_o = w_own0 ? m0dat_i : w_own1 ? m1dat_i : '0;
    assign wbswe_o  = (w_own0 & m0we_i) | (w_own1 & m1we_i);
    assign wbsstb_o = (w_own0 & m0stb_i & m0cyc_i) | (w_own1 & m1stb_i & m1cyc_i);
    assign wbscyc_o = (w_own0 & m0cyc_i) | (w_own1 & m1cyc_i);

    assign w_busy   = wbscyc_o & wbsstb_o;
    // an ack in the expiry cycle suppresses the error
    assign w_expire = (TMO_CYCLES != 0) && w_busy && !wbsack_i && (r_cnt == TMO_M1);

    assign m0ack_o   = wbsack_i & w_own0 & m0cyc_i;
    assign m1ack_o   = wbsack_i & w_own1 & m1cyc_i;
    assign m0err_o   = w_expire & w_own0;
    assign m1err_o   = w_expire & w_own1;
    assign m0stall_o = ~w_own0;
    assign m1stall_o = ~w_own1;
    assign m0dat_o   = reset_i ? wbsdat_i : '0;
    assign m1dat_o   = reset_i ? wbsdat_i : '0;
    assign gnt_o     = {w_own1, w_own0};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != IDLE && w_next != r_state)
                r_last <= (r_state == OWN1);
            r_cnt <= (!w_busy || wbsack_i || w_expire || w_next != r_state) ? '0 : r_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of two arbiter configurations against an ownership model
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset_i;
    logic [63:0] m0adr, m1adr;
    logic [15:0] m0dat, m1dat;
    logic        m0we, m1we, m0stb, m1stb, m0cyc, m1cyc;
    logic        wbsack;
    logic [15:0] wbsdat;

    logic [1:0]  a_ack, a_err, a_stall, a_gnt, b_ack, b_err, b_stall, b_gnt;
    logic [15:0] a_d0, a_d1, b_d0, b_d1, a_sdat, b_sdat;
    logic [63:0] a_sadr, b_sadr;
    logic        a_swe, a_sstb, a_scyc, b_swe, b_sstb, b_scyc;

    int n_chk = 0;
    int n_fail = 0;

    int own[2];
    int last[2];
    int run[2];
    int rr[2] = '{1, 0};
    int tmo[2] = '{4, 0};

    always #5 clk = ~clk;

    wb_arbiter #(.ROUND_ROBIN(1), .TMO_CYCLES(4)) u_a (
        .clk_i(clk), .reset_i(reset_i),
        .m0adr_i(m0adr), .m1adr_i(m1adr), .m0dat_i(m0dat), .m1dat_i(m1dat),
        .m0we_i(m0we), .m1we_i(m1we), .m0stb_i(m0stb), .m1stb_i(m1stb),
        .m0cyc_i(m0cyc), .m1cyc_i(m1cyc),
        .m0ack_o(a_ack[0]), .m1ack_o(a_ack[1]), .m0err_o(a_err[0]), .m1err_o(a_err[1]),
        .m0stall_o(a_stall[0]), .m1stall_o(a_stall[1]), .m0dat_o(a_d0), .m1dat_o(a_d1),
        .wbsadr_o(a_sadr), .wbsdat_o(a_sdat), .wbswe_o(a_swe), .wbsstb_o(a_sstb),
        .wbscyc_o(a_scyc), .wbsack_i(wbsack), .wbsdat_i(wbsdat), .gnt_o(a_gnt)
    );

    wb_arbiter #(.ROUND_ROBIN(0), .TMO_CYCLES(0)) u_b (
        .clk_i(clk), .reset_i(reset_i),
        .m0adr_i(m0adr), .m1adr_i(m1adr), .m0dat_i(m0dat), .m1dat_i(m1dat),
        .m0we_i(m0we), .m1we_i(m1we), .m0stb_i(m0stb), .m1stb_i(m1stb),
        .m0cyc_i(m0cyc), .m1cyc_i(m1cyc),
        .m0ack_o(b_ack[0]), .m1ack_o(b_ack[1]), .m0err_o(b_err[0]), .m1err_o(b_err[1]),
        .m0stall_o(b_stall[0]), .m1stall_o(b_stall[1]), .m0dat_o(b_d0), .m1dat_o(b_d1),
        .wbsadr_o(b_sadr), .wbsdat_o(b_sdat), .wbswe_o(b_swe), .wbsstb_o(b_sstb),
        .wbscyc_o(b_scyc), .wbsack_i(wbsack), .wbsdat_i(wbsdat), .gnt_o(b_gnt)
    );

    task automatic chk(input int k, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL dut%0d %s observed=%h expected=%h", k, tag, obs, exp);
        end
    endtask

    function automatic int cur_owner(input int k);
        return reset_i ? own[k] : -1;
    endfunction

    function automatic bit m_cyc(input int j);
        return (j == 0) ? m0cyc : m1cyc;
    endfunction

    function automatic bit m_stb(input int j);
        return (j == 0) ? m0stb : m1stb;
    endfunction

    function automatic bit busy(input int k);
        int o = cur_owner(k);
        return (o >= 0) && m_cyc(o) && m_stb(o);
    endfunction

    function automatic bit timeout(input int k);
        return busy(k) && !wbsack && tmo[k] != 0 && run[k] == tmo[k] - 1;
    endfunction

    task automatic check_dut(input int k, input logic [1:0] ack, input logic [1:0] err,
                             input logic [1:0] stall, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [63:0] sadr, input logic [15:0] sdat, input logic swe,
                             input logic sstb, input logic scyc, input logic [1:0] gnt);
        int o = cur_owner(k);
        logic [1:0] e_ack, e_err, e_stall, e_gnt;
        for (int j = 0; j < 2; j++) begin
            e_ack[j]   = (o == j) && m_cyc(j) && wbsack;
            e_err[j]   = (o == j) && timeout(k);
            e_stall[j] = (o != j);
            e_gnt[j]   = (o == j);
        end
        chk(k, "gnt", gnt, e_gnt);
        chk(k, "stall", stall, e_stall);
        chk(k, "ack", ack, e_ack);
        chk(k, "err", err, e_err);
        chk(k, "scyc", scyc, (o >= 0) && m_cyc(o));
        chk(k, "sstb", sstb, busy(k));
        chk(k, "sadr", sadr, o == 0 ? m0adr : o == 1 ? m1adr : 64'd0);
        chk(k, "sdat", sdat, o == 0 ? m0dat : o == 1 ? m1dat : 16'd0);
        chk(k, "swe", swe, o == 0 ? m0we : o == 1 ? m1we : 1'b0);
        chk(k, "mdat0", d0, reset_i ? wbsdat : 16'd0);
        chk(k, "mdat1", d1, reset_i ? wbsdat : 16'd0);
    endtask

    task automatic settle();
        @(negedge clk);
        check_dut(0, a_ack, a_err, a_stall, a_d0, a_d1, a_sadr, a_sdat, a_swe, a_sstb, a_scyc, a_gnt);
        check_dut(1, b_ack, b_err, b_stall, b_d0, b_d1, b_sadr, b_sdat, b_swe, b_sstb, b_scyc, b_gnt);
    endtask

    task automatic advance();
        for (int k = 0; k < 2; k++) begin
            if (!reset_i) begin
                own[k] = -1;
                last[k] = 1;
                run[k] = 0;
            end else begin
                int o = own[k];
                int n = o;
                bit expired = timeout(k);
                bit b = busy(k);
                if (o < 0)
                    n = (m0cyc && m1cyc) ? (rr[k] != 0 ? 1 - last[k] : 1) : m0cyc ? 0 : m1cyc ? 1 : -1;
                else if (!m_cyc(o)) begin
                    n = m_cyc(1 - o) ? 1 - o : -1;
                    last[k] = o;
                end
                run[k] = (n != o || !b || wbsack || expired) ? 0 : run[k] + 1;
                own[k] = n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b0;
        {m0adr, m1adr, m0dat, m1dat, m0we, m1we, m0stb, m1stb, m0cyc, m1cyc, wbsack} = '0;
        wbsdat = 16'h5A5A;
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; last[k] = 1; run[k] = 0;
        end
        settle();
        chk(0, "rst_gnt", a_gnt, 2'b00);
        chk(0, "rst_stall", a_stall, 2'b11);
        chk(0, "rst_scyc", a_scyc, 1'b0);
        chk(0, "rst_mdat", a_d0, 16'd0);
        advance();
        reset_i = 1'b1;
        settle();
        advance();
        // tie right after reset
        m0cyc = 1; m1cyc = 1; m0stb = 1; m1stb = 1;
        m0adr = {$urandom, $urandom}; m1adr = {$urandom, $urandom};
        m0dat = 16'($urandom); m1dat = 16'($urandom); m0we = 1;
        settle();
        chk(0, "tie_lat", a_gnt, 2'b00);
        advance();
        wbsack = 1; wbsdat = 16'hBEEF;
        settle();
        chk(0, "tie_gnt", a_gnt, 2'b01);
        chk(0, "tie_stall1", a_stall[1], 1'b1);
        chk(0, "tie_adr", a_sadr, m0adr);
        chk(0, "ack_route", a_ack, 2'b01);
        chk(0, "ack_dat", a_d0, 16'hBEEF);
        chk(1, "fixed_gnt", b_gnt, 2'b10);
        advance();
        wbsack = 0;
        repeat (3) begin
            settle();
            chk(0, "pre_exp_err", a_err, 2'b00);
            advance();
        end
        wbsack = 1;
        settle();
        chk(0, "ack_vs_exp_ack", a_ack, 2'b01);
        chk(0, "ack_vs_exp_err", a_err, 2'b00);
        advance();
        wbsack = 0; m0cyc = 0;
        settle();
        chk(0, "drop_gnt", a_gnt, 2'b01);
        chk(0, "drop_scyc", a_scyc, 1'b0);
        advance();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk(0, "handoff_gnt", a_gnt, 2'b10);
            chk(0, "wd_err", a_err, i == 3 ? 2'b10 : 2'b00);
            if (i == 0) chk(0, "handoff_adr", a_sadr, m1adr);
            advance();
        end
        settle();
        chk(0, "wd_after_err", a_err, 2'b00);
        chk(0, "wd_keep_gnt", a_gnt, 2'b10);
        advance();
        m1cyc = 0;
        settle();
        advance();
        m0cyc = 1; m1cyc = 1;
        settle();
        chk(0, "tie2_idle", a_gnt, 2'b00);
        advance();
        settle();
        chk(0, "tie2_gnt", a_gnt, 2'b01);
        chk(1, "fixed_gnt2", b_gnt, 2'b10);
        advance();
        m0cyc = 0;
        settle();
        advance();
        // asynchronous reset between edges while a owns m1
        wbsack = 1;
        #2;
        reset_i = 1'b0;
        #1;
        chk(0, "arst_scyc", a_scyc, 1'b0);
        chk(0, "arst_gnt", a_gnt, 2'b00);
        chk(0, "arst_ack", a_ack, 2'b00);
        chk(0, "arst_err", a_err, 2'b00);
        chk(0, "arst_stall", a_stall, 2'b11);
        chk(1, "arst_gnt", b_gnt, 2'b00);
        settle();
        advance();
        reset_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) m0cyc = ~m0cyc;
            if ($urandom_range(0, 5) == 0) m1cyc = ~m1cyc;
            m0stb = ($urandom_range(0, 3) != 0);
            m1stb = ($urandom_range(0, 3) != 0);
            m0we = 1'($urandom); m1we = 1'($urandom);
            m0adr = {$urandom, $urandom}; m1adr = {$urandom, $urandom};
            m0dat = 16'($urandom); m1dat = 16'($urandom);
            wbsack = ($urandom_range(0, 3) == 0);
            wbsdat = 16'($urandom);
            reset_i = ($urandom_range(0, 99) != 0);
            settle();
            advance();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, meaning: 1 = round-robin on tie, 0 = fixed priority to master 1 (LSU).
REQ-002 Parameter TMO_CYCLES, default 255, meaning: no-ack watchdog limit in cycles; 0 disables the watchdog.
REQ-003 clk_i  in  1  sole clock, all state changes on the rising edge.
REQ-004 reset_i  in  1  reset, asynchronous, active-low.
REQ-005 m0adr_i, m1adr_i  in  64 each  master address (m0 = instruction fetch, m1 = LSU).
REQ-006 m0dat_i, m1dat_i  in  16 each  master write data.
REQ-007 m0we_i, m1we_i, m0stb_i, m1stb_i, m0cyc_i, m1cyc_i  in  1 each  master write enable, strobe and cycle.
REQ-008 m0ack_o, m1ack_o  out  1 each  routed acknowledge.
REQ-009 m0err_o, m1err_o  out  1 each  watchdog error pulse.
REQ-010 m0stall_o, m1stall_o  out  1 each  master not granted; the master holds adr/dat/we/stb.
REQ-011 m0dat_o, m1dat_o  out  16 each  read data, both driven from wbsdat_i.
REQ-012 wbsadr_o 64, wbsdat_o 16, wbswe_o 1, wbsstb_o 1, wbscyc_o 1  out  shared slave-side bus.
REQ-013 wbsack_i 1, wbsdat_i 16  in  slave acknowledge and read data.
REQ-014 gnt_o  out  2  {owner1, owner0}, one-hot or zero.

Function
REQ-015 The FSM SHALL have states IDLE, OWN0 and OWN1, plus a register last (the last owner).
- A state change SHALL take effect on the clock edge after the request is sampled: the grant is registered, with one cycle of latency.
REQ-016 IDLE transitions:
- Only m0cyc_i high -> OWN0.
- Only m1cyc_i high -> OWN1.
- Neither high -> remain in IDLE.
- Both high -> OWN(~last) when ROUND_ROBIN=1, otherwise OWN1.
REQ-017 OWNx transitions:
- The FSM SHALL hold OWNx while mxcyc_i is high, regardless of the other master's requests.
- When mxcyc_i is low: go to OWN(other) if the other master's cyc is high, otherwise to IDLE.
- On leaving OWNx, last SHALL be set to x.
REQ-018 In OWNx, the wbs* outputs SHALL equal the owner's adr/dat/we/stb/cyc combinationally, with wbsstb_o and wbscyc_o gated by mxcyc_i.
REQ-019 In IDLE, all wbs* outputs SHALL be 0.
REQ-020 Acknowledge routing:
- mxack_o = wbsack_i AND state==OWNx AND mxcyc_i.
- The non-owner's ack SHALL be 0.
REQ-021 mxstall_o SHALL equal NOT(state==OWNx).
REQ-022 A 16-bit counter SHALL increment each cycle in which wbscyc_o and wbsstb_o are high and wbsack_i is low.
- It SHALL clear on wbsack_i, on any state change, and when wbscyc_o is low.
REQ-023 When the counter equals TMO_CYCLES-1 and wbsack_i is low (TMO_CYCLES≠0):
- mxerr_o of the owner SHALL be high for exactly one cycle.
- The counter SHALL clear at the same time.
- The arbiter SHALL NOT revoke the grant; it releases only when the owner drops cyc.
REQ-024 If wbsack_i and watchdog expiry coincide, the ack SHALL win and no err is issued.
REQ-025 A handoff (OWNx -> OWN(other)) SHALL insert no IDLE cycle.
- The new owner's first stb SHALL appear on the bus in the cycle after the old owner's cyc falls.
REQ-026 gnt_o SHALL equal {state==OWN1, state==OWN0}.

Reset
REQ-027 While reset_i is low, asynchronously:
- state=IDLE, last=1, counter=0.
- All mx*_o, wbs*_o and gnt_o SHALL be 0, except m0stall_o and m1stall_o, which SHALL be 1.
REQ-028 If reset is asserted mid-transaction, the bus SHALL be released immediately (wbscyc_o=0) with no ack or err.
- After reset deasserts, arbitration SHALL restart from IDLE with m0 favoured on a tie.

Verification
REQ-029 Tie after reset: m0cyc_i and m1cyc_i both rise in cycle 0 -> gnt_o=01 in cycle 1, m1stall_o=1, wbsadr_o=m0adr_i.
REQ-030 Round-robin handoff: m0 drops cyc in cycle 5 with m1cyc_i high -> gnt_o=10 in cycle 6, no IDLE cycle, then a second tie grants m0.
REQ-031 Fixed priority: ROUND_ROBIN=0 with both requesting -> gnt_o=10 every arbitration.
REQ-032 Watchdog: TMO_CYCLES=4, owner m1 strobes with no ack -> m1err_o high in the 4th stalled cycle only, counter=0 afterwards, gnt_o still 10.
REQ-033 Ack routing: owner m0 with wbsack_i=1 and wbsdat_i=16'hBEEF -> m0ack_o=1, m1ack_o=0, m0dat_o=16'hBEEF; ack coinciding with expiry -> no err.
REQ-034 Async reset mid-cycle: reset_i low between clock edges while OWN1 -> wbscyc_o=0 and gnt_o=00 before the next edge.
